mvm_out_writeback: RTL and testbench

MVM_OUT_WRITEBACK -- requirements
Module: mvm_out_writeback

---
 rtl/mvm_out_writeback_if.sv | 14 +
 rtl/mvm_out_writeback.sv | 114 +++++++++++
 tb/tb_mvm_out_writeback.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mvm_out_writeback_if.sv
// Write-back bus from the MVM output stage to the destination buffer.
// The master drives valid/address/data, and the slave returns ready.
interface mvm_out_writeback_if #(
  parameter int AW    = 8,
  parameter int OUT_W = 16
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic        [AW-1:0]    wr_addr;
  logic signed [OUT_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/mvm_out_writeback.sv
// Captures one set of MVM dot-product sums and writes them out one per transfer,
// rescaled by an arithmetic shift, optionally ReLU'd, and saturated to OUT_W.
module mvm_out_writeback #(
  parameter int N     = 16,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int AW    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_mvm_done,
  input  logic [N*ACC_W-1:0]   i_acc_in,
  input  logic [4:0]           i_shift,
  input  logic                 i_relu_en,
  input  logic [AW-1:0]        i_base_addr,
  mvm_out_writeback_if.master  wr,
  output logic                 o_busy,
  output logic                 o_wb_done,
  output logic                 o_overrun
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]              r_state;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_overrun;
  logic signed [ACC_W-1:0] r_acc [N];
  logic [4:0]              r_shift;
  logic                    r_relu;
  logic [AW-1:0]           r_base;

  logic w_drain;
  logic w_capture;
  logic w_xfer;
  logic w_last;

  // Clamp is applied to the full-width shifted value, so large sums saturate instead of wrapping.
  function automatic logic signed [OUT_W-1:0] f_rescale(
    input logic signed [ACC_W-1:0] x,
    input logic [4:0]              sh,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] s;
    int amt;
    amt = int'(sh);
    if (amt > ACC_W - 1) amt = ACC_W - 1;
    s = x >>> amt;
    if (relu && s < 0) s = '0;
    if (s > SAT_MAX) s = SAT_MAX;
    if (s < SAT_MIN) s = SAT_MIN;
    return s[OUT_W-1:0];
  endfunction

  assign w_drain   = (r_state == S_DRAIN);
  assign w_capture = (r_state == S_IDLE) && i_mvm_done;
  assign w_xfer    = w_drain && wr.wr_ready;
  assign w_last    = (r_idx == IDX_W'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_mvm_done) begin
            r_state <= S_DRAIN;
            r_idx   <= '0;
          end
        end
        S_DRAIN: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
          if (i_mvm_done) r_overrun <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          if (i_mvm_done) r_overrun <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand capture: only an accepted pulse in IDLE loads the snapshot.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < N; i++) r_acc[i] <= $signed(i_acc_in[i*ACC_W +: ACC_W]);
      r_shift <= i_shift;
      r_relu  <= i_relu_en;
      r_base  <= i_base_addr;
    end
  end

  assign wr.wr_valid = w_drain;
  assign wr.wr_addr  = w_drain ? AW'(r_base + AW'(r_idx)) : '0;
  assign wr.wr_data  = w_drain ? f_rescale(r_acc[r_idx], r_shift, r_relu) : '0;
  assign o_busy      = (r_state != S_IDLE);
  assign o_wb_done   = (r_state == S_DONE);
  assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_mvm_out_writeback.sv
// Directed and randomized bench for mvm_out_writeback (N=4, ACC_W=32, OUT_W=16, AW=8)
// with an arithmetic reference model for the rescale/ReLU/saturate transform.
module tb_mvm_out_writeback;
  localparam int N = 4, ACC_W = 32, OUT_W = 16, AW = 8;
  typedef int sums_t [4];

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               mvm_done = 1'b0;
  logic [N*ACC_W-1:0] acc_in = '0;
  logic [4:0]         shift = '0;
  logic               relu_en = 1'b0;
  logic [AW-1:0]      base_addr = '0;
  logic               busy, wb_done, overrun;
  int                 pass_cnt = 0;
  int                 total = 0;

  mvm_out_writeback_if #(.AW(AW), .OUT_W(OUT_W)) wb ();

  mvm_out_writeback #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .AW(AW)) dut (
    .clk(clk), .reset(reset), .i_mvm_done(mvm_done), .i_acc_in(acc_in),
    .i_shift(shift), .i_relu_en(relu_en), .i_base_addr(base_addr),
    .wr(wb), .o_busy(busy), .o_wb_done(wb_done), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // floor(x / 2^s) with the shift capped at 31, then ReLU, then clamp to 16-bit signed.
  function automatic longint model_f(input longint x, input int sh, input bit relu);
    longint d, q;
    int s;
    s = (sh > 31) ? 31 : sh;
    d = longint'(1) << s;
    q = x / d;
    if (x < 0 && q * d != x) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic drive_op(input sums_t a, input int sh, input bit relu, input int base);
    for (int i = 0; i < N; i++) acc_in[i*ACC_W +: ACC_W] = a[i];
    shift     = sh[4:0];
    relu_en   = relu;
    base_addr = base[7:0];
    mvm_done  = 1'b1;
  endtask

  // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: random ready.
  task automatic run_op(input string tag, input sums_t a, input int sh, input bit relu,
                        input int base, input int mode, input int inject_at);
    longint got_a[$];
    longint got_d[$];
    int     first_c, done_c;
    bit     stalled, rdy;
    longint pa, pd;
    @(negedge clk);
    drive_op(a, sh, relu, base);
    @(negedge clk);
    mvm_done  = 1'b0;
    acc_in    = {$urandom, $urandom, $urandom, $urandom};
    base_addr = 8'($urandom);
    shift     = 5'($urandom);
    relu_en   = ~relu;
    first_c = -1; done_c = -1; stalled = 1'b0; pa = 0; pd = 0;
    for (int c = 1; c <= 60 && done_c < 0; c++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 3) == 1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      wb.wr_ready = rdy;
      if (stalled) begin
        chk({tag, "_hold_valid"}, longint'(wb.wr_valid), 1);
        chk({tag, "_hold_addr"}, longint'(wb.wr_addr), pa);
        chk({tag, "_hold_data"}, longint'($signed(wb.wr_data)), pd);
      end
      if (c == inject_at) begin
        mvm_done  = 1'b1;
        acc_in    = {$urandom, $urandom, $urandom, $urandom};
        base_addr = 8'($urandom);
      end else begin
        mvm_done = 1'b0;
      end
      if (wb.wr_valid) begin
        if (first_c < 0) first_c = c;
        pa = longint'(wb.wr_addr);
        pd = longint'($signed(wb.wr_data));
        if (rdy) begin
          got_a.push_back(pa);
          got_d.push_back(pd);
        end
        stalled = !rdy;
      end else begin
        stalled = 1'b0;
      end
      if (wb_done) done_c = c;
      @(negedge clk);
    end
    mvm_done = 1'b0;
    chk({tag, "_timeout"}, longint'(done_c > 0), 1);
    chk({tag, "_done_pulse"}, longint'(wb_done), 0);
    chk({tag, "_idle_busy"}, longint'(busy), 0);
    chk({tag, "_idle_valid"}, longint'(wb.wr_valid), 0);
    chk({tag, "_count"}, longint'(got_a.size()), N);
    for (int i = 0; i < N && i < got_a.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), got_a[i], longint'((base + i) % 256));
      chk($sformatf("%s_data%0d", tag, i), got_d[i], model_f(longint'(a[i]), sh, relu));
    end
    chk({tag, "_first_valid"}, longint'(first_c), 1);
    if (mode == 0) chk({tag, "_wb_done_lat"}, longint'(done_c), N + 1);
  endtask

  initial begin
    sums_t a;
    int    tmp;
    wb.wr_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", longint'(wb.wr_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_wb_done", longint'(wb_done), 0);
    chk("rst_overrun", longint'(overrun), 0);
    chk("rst_addr", longint'(wb.wr_addr), 0);
    chk("rst_data", longint'($signed(wb.wr_data)), 0);
    reset = 1'b0;

    run_op("basic", '{100, -200, 300, -400}, 0, 1'b0, 'h10, 0, 0);
    run_op("relu_sh2", '{100, -200, 300, -400}, 2, 1'b1, 'h10, 0, 0);
    run_op("sat_sh0", '{'h00100000, -'h00100000, 32767, -32768}, 0, 1'b0, 'h20, 0, 0);
    run_op("sat_sh31", '{'h00100000, -'h00100000, 32767, -32768}, 31, 1'b0, 'h20, 0, 0);
    run_op("toggle_rdy", '{7, -8, 9, -10}, 0, 1'b0, 'h40, 1, 0);
    run_op("wrap", '{1, 2, 3, 4}, 0, 1'b0, 'hFE, 0, 0);
    chk("no_overrun_yet", longint'(overrun), 0);

    run_op("inject", '{111, -222, 333, -444}, 0, 1'b0, 'h30, 0, 2);
    chk("overrun_set", longint'(overrun), 1);
    run_op("after_inj", '{5, 6, 7, 8}, 1, 1'b0, 'h50, 0, 0);
    chk("overrun_sticky", longint'(overrun), 1);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) begin
        tmp  = int'($urandom);
        a[i] = tmp >>> $urandom_range(0, 20);
      end
      run_op($sformatf("rand%0d", t), a, int'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 2, 0);
    end

    // Abort a write-back with reset after one transfer.
    @(negedge clk);
    drive_op('{1, 2, 3, 4}, 0, 1'b0, 'h60);
    wb.wr_ready = 1'b1;
    @(negedge clk);
    mvm_done = 1'b0;
    chk("abort_pre_valid", longint'(wb.wr_valid), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_valid", longint'(wb.wr_valid), 0);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_overrun", longint'(overrun), 0);
    chk("abort_addr", longint'(wb.wr_addr), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("abort_quiet%0d", k), longint'(wb.wr_valid), 0);
    end

    // Reset wins over a coincident mvm_done.
    reset = 1'b1;
    drive_op('{9, 9, 9, 9}, 0, 1'b0, 'h70);
    @(negedge clk);
    reset = 1'b0;
    mvm_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_prio%0d", k), longint'(wb.wr_valid), 0);
      @(negedge clk);
    end
    run_op("post_rst", '{-1, 65536, -70000, 0}, 0, 1'b0, 'h80, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
